par_to_ser: RTL and testbench

- Consumer end of the parallel nibble source.
- Requests each parallel word by pulsing ask_for_data, then captures the word a fixed number of cycles later.
- Shifts the captured word out MSB-first as a two-wire serial frame (scl/sda) with start and stop conditions.
- Sits between the parallel data generator and any serial receiver; all logic is on sclk.

---
 rtl/par_to_ser.sv | 236 +++++++++++++++++++++++
 tb/tb_par_to_ser.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/par_to_ser.sv
// -----------------------------------------------------------------------------
// par_to_ser
//
// Consumer end of the parallel nibble source. Each frame requests a word with
// a one-cycle ask_for_data pulse, waits DATA_WAIT cycles for the source to
// settle, captures the word, and then sends it MSB-first on a two-wire serial
// link (scl/sda). Each frame is bracketed by a start condition (sda falls
// while scl is high) and a stop condition (sda rises while scl is high).
//
// Frame timing in sclk cycles:
//   REQ(1) WAIT(DATA_WAIT) LOAD(1) START(2) BITS(2*DATA_W) [PARITY(2)]
//   STOP(3) DONE(1)
//
// Parameters:
//   DATA_W    - parallel word width and number of serial data bits per frame
//   DATA_WAIT - cycles from the end of the request pulse to the capture cycle;
//               the legal range is 1..15
//
// Ports:
//   sclk         in   system clock; all state changes on its rising edge
//   rst          in   synchronous active-low reset
//   en           in   run enable; a new frame starts only while high
//   data         in   parallel word from the source, sampled in LOAD only
//   ask_for_data out  registered one-cycle request pulse
//   scl          out  registered serial clock line
//   sda          out  registered serial data line
//   frame_done   out  registered one-cycle pulse once the stop completes
//
// Build option:
//   PAR_TO_SER_PARITY_EN - when defined, an extra 2-cycle bit slot after the
//                          last data bit carries the even parity (XOR) of the
//                          captured word.
// -----------------------------------------------------------------------------
module par_to_ser #(
    parameter int DATA_W    = 4,
    parameter int DATA_WAIT = 2
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic              ask_for_data,
    output logic              scl,
    output logic              sda,
    output logic              frame_done
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Reload values for the down-counters; both count to zero, so neither
    // can overflow for legal parameter values.
    localparam logic [3:0]       WAIT_LAST = 4'(DATA_WAIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LOAD,
        S_START,
        S_BITS,
`ifdef PAR_TO_SER_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;      // captured word, MSB is the bit on the line
    logic [3:0]        wait_cnt;   // counts the WAIT cycles down to zero
    logic [1:0]        phase;      // sub-cycle inside START, a bit slot or STOP
    logic [BIT_W-1:0]  bit_cnt;    // data bits still to send, minus one
`ifdef PAR_TO_SER_PARITY_EN
    logic              parity_bit; // XOR of the captured word
`endif

    // The word as it looks after the next shift; its MSB is the next bit.
    logic [DATA_W-1:0] shreg_next;

    always_comb begin
        shreg_next = shreg << 1;
    end

    // Every output is a flop. The outputs for a state are loaded on the edge
    // that enters that state, so each line already shows the new state's
    // value during the state's first cycle and nothing on it is decoded
    // combinationally.
    always_ff @(posedge sclk) begin
        // NOTE: the shift register and counters are ordinary flops, so they
        // are reset along with the state; only RAM arrays are left unreset.
        if (!rst) begin
            state        <= S_IDLE;
            ask_for_data <= 1'b0;
            scl          <= 1'b1;
            sda          <= 1'b1;
            frame_done   <= 1'b0;
            shreg        <= '0;
            wait_cnt     <= '0;
            phase        <= '0;
            bit_cnt      <= '0;
`ifdef PAR_TO_SER_PARITY_EN
            parity_bit   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so a later default
            // never races an earlier read within the same edge.
            // The two pulse outputs are low unless a branch below raises them.
            ask_for_data <= 1'b0;
            frame_done   <= 1'b0;

            case (state)
                S_IDLE: begin
                    scl <= 1'b1;
                    sda <= 1'b1;
                    if (en) begin
                        state        <= S_REQ;
                        ask_for_data <= 1'b1;
                    end
                end

                S_REQ: begin
                    state    <= S_WAIT;
                    wait_cnt <= WAIT_LAST;
                end

                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                S_LOAD: begin
                    // The only cycle in which data is sampled.
                    shreg      <= data;
`ifdef PAR_TO_SER_PARITY_EN
                    parity_bit <= ^data;
`endif
                    state      <= S_START;
                    phase      <= 2'd0;
                end

                S_START: begin
                    if (phase == 2'd0) begin
                        // sda falls while scl stays high: the start condition.
                        phase <= 2'd1;
                        sda   <= 1'b0;
                    end else begin
                        state   <= S_BITS;
                        phase   <= 2'd0;
                        bit_cnt <= BIT_LAST;
                        scl     <= 1'b0;
                        sda     <= shreg[DATA_W-1];
                    end
                end

                S_BITS: begin
                    if (phase == 2'd0) begin
                        scl   <= 1'b1;
                        phase <= 2'd1;
                    end else begin
                        // Falling scl: shift and present the next bit while
                        // scl is low.
                        shreg <= shreg_next;
                        phase <= 2'd0;
                        scl   <= 1'b0;
                        if (bit_cnt == '0) begin
`ifdef PAR_TO_SER_PARITY_EN
                            state <= S_PARITY;
                            sda   <= parity_bit;
`else
                            state <= S_STOP;
                            sda   <= 1'b0;
`endif
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            sda     <= shreg_next[DATA_W-1];
                        end
                    end
                end

`ifdef PAR_TO_SER_PARITY_EN
                S_PARITY: begin
                    if (phase == 2'd0) begin
                        scl   <= 1'b1;
                        phase <= 2'd1;
                    end else begin
                        state <= S_STOP;
                        phase <= 2'd0;
                        scl   <= 1'b0;
                        sda   <= 1'b0;
                    end
                end
`endif

                S_STOP: begin
                    case (phase)
                        2'd0: begin
                            scl   <= 1'b1;
                            phase <= 2'd1;
                        end
                        2'd1: begin
                            // sda rises while scl is high: the stop condition.
                            sda   <= 1'b1;
                            phase <= 2'd2;
                        end
                        default: begin
                            state      <= S_DONE;
                            phase      <= 2'd0;
                            frame_done <= 1'b1;
                        end
                    endcase
                end

                S_DONE: begin
                    // Back-to-back frames go straight to the next request.
                    if (en) begin
                        state        <= S_REQ;
                        ask_for_data <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    scl   <= 1'b1;
                    sda   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_par_to_ser.sv
// -----------------------------------------------------------------------------
// tb_par_to_ser
//
// Self-checking bench for par_to_ser. A reference model describes each frame
// as a waveform table indexed by the cycle offset from the request. The table
// is built from the state durations and line levels, and the model compares
// it with all four outputs on every falling edge. A separate serial monitor
// decodes frames from scl/sda alone, using the start and stop conditions and
// rising scl, and compares each decoded word with the word the model says
// was present in the capture cycle.
// -----------------------------------------------------------------------------
module tb_par_to_ser;

    localparam int DATA_W    = 4;
    localparam int DATA_WAIT = 2;
`ifdef PAR_TO_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    // Frame offsets from the REQ cycle (offset 0).
    localparam int LOAD_IDX  = 1 + DATA_WAIT;
    localparam int START_IDX = LOAD_IDX + 1;
    localparam int BITS_IDX  = START_IDX + 2;
    localparam int STOP_IDX  = BITS_IDX + 2 * (DATA_W + PAR);
    localparam int DONE_IDX  = STOP_IDX + 3;
    localparam int FRAME_LEN = DONE_IDX + 1;

    logic              sclk = 1'b0;
    logic              rst;
    logic              en;
    logic [DATA_W-1:0] data;
    logic              ask_for_data;
    logic              scl;
    logic              sda;
    logic              frame_done;

    int errors = 0;
    int checks = 0;

    par_to_ser #(
        .DATA_W   (DATA_W),
        .DATA_WAIT(DATA_WAIT)
    ) dut (
        .sclk        (sclk),
        .rst         (rst),
        .en          (en),
        .data        (data),
        .ask_for_data(ask_for_data),
        .scl         (scl),
        .sda         (sda),
        .frame_done  (frame_done)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Word as it appears on the line: data bits, then parity when enabled.
    function automatic int exp_word(input logic [DATA_W-1:0] w);
        int e;
        e = int'(w);
        if (PAR != 0) e = (e << 1) | int'(^w);
        return e;
    endfunction

    // Expected {ask_for_data, scl, sda, frame_done} at a frame offset.
    function automatic logic [3:0] wave(input int p, input logic [DATA_W-1:0] w);
        logic [DATA_W:0] slot;
        int              k;
        slot = {w, ^w};
        if (p < 0)              return 4'b0110;   // idle
        if (p == 0)             return 4'b1110;   // request
        if (p <= START_IDX)     return 4'b0110;   // wait, load, start phase 0
        if (p == START_IDX + 1) return 4'b0100;   // start: sda low, scl high
        if (p < STOP_IDX) begin
            k = (p - BITS_IDX) / 2;
            return {1'b0, ((p - BITS_IDX) % 2) == 1, slot[DATA_W - k], 1'b0};
        end
        if (p == STOP_IDX)      return 4'b0000;
        if (p == STOP_IDX + 1)  return 4'b0100;
        if (p == STOP_IDX + 2)  return 4'b0110;
        return 4'b0111;                            // done
    endfunction

    // ---------------- reference model ----------------
    int                pos = -1;
    logic [DATA_W-1:0] cap = '0;
    logic [3:0]        exp_o;
    int                exp_q[$];
    bit                chk_en = 1'b0;

    always @(posedge sclk) begin
        if (!rst) begin
            pos = -1;
            exp_q.delete();
        end else if (pos < 0) begin
            if (en) pos = 0;
        end else if (pos == DONE_IDX) begin
            pos = en ? 0 : -1;
        end else begin
            if (pos == LOAD_IDX) begin
                cap = data;
                exp_q.push_back(exp_word(data));
            end
            pos++;
        end
        exp_o = wave(pos, cap);
    end

    always @(negedge sclk) begin
        if (chk_en) check($sformatf("outs@%0d", pos), {ask_for_data, scl, sda, frame_done}, exp_o);
    end

    // ---------------- serial monitor ----------------
    logic        pscl = 1'b1;
    logic        psda = 1'b1;
    bit          in_frame = 1'b0;
    int          nbits = 0;
    logic [15:0] sh = '0;
    int          dec_last = -1;
    int          dec_cnt = 0;
    int          dec_words[$];

    always @(negedge sclk) begin
        if (rst !== 1'b1) begin
            in_frame = 1'b0;
            nbits    = 0;
        end else if (pscl === 1'b1 && scl === 1'b1 && psda === 1'b1 && sda === 1'b0) begin
            in_frame = 1'b1;
            nbits    = 0;
            sh       = '0;
        end else if (in_frame && pscl === 1'b0 && scl === 1'b1) begin
            sh = {sh[14:0], sda};
            nbits++;
        end else if (in_frame && pscl === 1'b1 && scl === 1'b1 && psda === 1'b0 && sda === 1'b1) begin
            in_frame = 1'b0;
            // The scl rise that opens the stop condition is also sampled; drop it.
            check("frame_bits", nbits, DATA_W + PAR + 1);
            dec_last = int'(sh >> 1);
            dec_cnt++;
            dec_words.push_back(dec_last);
            if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
            else                   check("frame_word", dec_last, exp_q.pop_front());
        end
        pscl = scl;
        psda = sda;
    end

    // ---------------- stimulus ----------------
    bit inc_mode = 1'b0;
    bit rnd_data = 1'b0;
    int ask_cnt  = 0;
    int done_cnt = 0;

    task automatic step();
        @(posedge sclk);
        #1;
        if (ask_for_data === 1'b1) ask_cnt++;
        if (frame_done === 1'b1) done_cnt++;
        if (inc_mode && ask_for_data === 1'b1) data = data + 1'b1;
        if (rnd_data) data = DATA_W'($urandom);
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (frame_done !== 1'b1 && n < 400);
        if (frame_done !== 1'b1) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_pos(input string tag, input int p);
        int n;
        n = 0;
        while (pos != p && n < 400) begin
            step();
            n++;
        end
        if (pos != p) check({tag, "_timeout"}, pos, p);
    endtask

    initial begin
        int n;
        int c0;
        rst  = 1'b0;
        en   = 1'b0;
        data = '0;
        repeat (3) step();
        chk_en = 1'b1;
        check("reset_outs", {ask_for_data, scl, sda, frame_done}, 4'b0110);
        rst = 1'b1;
        step();

        // Single frame of 1010, en dropped once the request is seen.
        en = 1'b1;
        data = 4'b1010;
        ask_cnt = 0;
        step();
        check("t1_req", ask_for_data, 1'b1);
        en = 1'b0;
        wait_done("t1", n);
        check("t1_done_latency", n, DONE_IDX);
        repeat (4) step();
        check("t1_ask_pulses", ask_cnt, 1);
        check("t1_word", dec_last, exp_word(4'b1010));

        // Back-to-back frames; the source increments after each request.
        dec_words.delete();
        data = '0;
        inc_mode = 1'b1;
        en = 1'b1;
        wait_done("t2a", n);
        wait_done("t2b", n);
        check("t2_spacing1", n, FRAME_LEN);
        wait_done("t2c", n);
        check("t2_spacing2", n, FRAME_LEN);
        en = 1'b0;
        inc_mode = 1'b0;
        repeat (4) step();
        check("t2_frames", dec_words.size(), 3);
        for (int i = 0; i < 3 && i < dec_words.size(); i++)
            check($sformatf("t2_word%0d", i), dec_words[i], exp_word(DATA_W'(i + 1)));

        // Data changing every cycle: only the capture-cycle word is sent.
        c0 = dec_cnt;
        rnd_data = 1'b1;
        en = 1'b1;
        repeat (3) wait_done("t3", n);
        en = 1'b0;
        rnd_data = 1'b0;
        repeat (4) step();
        check("t3_frames", dec_cnt - c0, 3);

        // Reset during the third data bit: no stop, restart on release.
        data = 4'b0110;
        en = 1'b1;
        wait_pos("t4", BITS_IDX + 4);
        c0 = dec_cnt;
        rst = 1'b0;
        step();
        check("t4_reset_outs", {ask_for_data, scl, sda, frame_done}, 4'b0110);
        rst = 1'b1;
        step();
        check("t4_req_after", ask_for_data, 1'b1);
        check("t4_no_frame", dec_cnt - c0, 0);
        en = 1'b0;
        wait_done("t4", n);

        // en dropped during START: frame completes, then stays idle.
        repeat (2) step();
        en = 1'b1;
        wait_pos("t5", START_IDX);
        en = 1'b0;
        ask_cnt = 0;
        done_cnt = 0;
        repeat (2 * FRAME_LEN) step();
        check("t5_done_pulses", done_cnt, 1);
        check("t5_no_ask", ask_cnt, 0);
        check("t5_idle_outs", {ask_for_data, scl, sda, frame_done}, 4'b0110);

        // Parity-sensitive words (parity slot present only in that build).
        data = 4'b1011;
        en = 1'b1;
        step();
        en = 1'b0;
        wait_done("t6a", n);
        check("t6_latency", n, DONE_IDX);
        check("t6_word_1011", dec_last, exp_word(4'b1011));
        step();
        data = 4'b1001;
        en = 1'b1;
        step();
        en = 1'b0;
        wait_done("t6b", n);
        check("t6_word_1001", dec_last, exp_word(4'b1001));

        // Random run with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst  = ($urandom_range(0, 199) != 0);
            en   = ($urandom_range(0, 7) != 0);
            data = DATA_W'($urandom);
            step();
        end
        rst = 1'b1;
        en = 1'b0;
        repeat (2 * FRAME_LEN) step();
        check("final_idle", {ask_for_data, scl, sda, frame_done}, 4'b0110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
